// File: rtl/systolic_feeder_pkg.sv
// Shared constants and types for the systolic operand feeder.
package systolic_feeder_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned AW       = 2;
    localparam int unsigned BEAT_CNT = 2 * N - 1;
    localparam int unsigned TW       = $clog2(BEAT_CNT);
    // Skew difference is one bit wider than t so t-lane underflow is detectable.
    localparam int unsigned DIFW     = TW + 1;

    localparam logic WSEL_A = 1'b0;
    localparam logic WSEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/feeder_lane_mux.sv
// Selects element (t - lane) from one buffered row/column, or 0 outside the skew window.
module feeder_lane_mux
    import systolic_feeder_pkg::*;
(
    input  logic [N*DW-1:0] vec,
    input  logic [AW-1:0]   lane,
    input  logic [TW-1:0]   t,
    output logic [DW-1:0]   elem_c
);

    logic [DIFW-1:0] diff_c;

    always_comb begin
        diff_c = {1'b0, t} - DIFW'(lane);
        elem_c = '0;
        if (diff_c < DIFW'(N)) begin
            elem_c = vec[diff_c[AW-1:0]*DW +: DW];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers matrices A and B and streams skewed, zero-padded operands into the
// west (rows of A) and north (columns of B) edges of the PE array.
module systolic_feeder
    import systolic_feeder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_row,
    input  logic [AW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ready,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [N*DW-1:0] west_data,
    output logic [N*DW-1:0] north_data,
    output logic            stream_valid
);

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;

    logic [DW-1:0]   a_q [N][N];
    logic [DW-1:0]   a_d [N][N];
    logic [DW-1:0]   b_q [N][N];
    logic [DW-1:0]   b_d [N][N];

    logic [N*DW-1:0] west_q, west_d;
    logic [N*DW-1:0] north_q, north_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_ready_q, wr_ready_d;

    logic [N*DW-1:0] a_row_c [N];
    logic [N*DW-1:0] b_col_c [N];
    logic [DW-1:0]   west_lane_c [N];
    logic [DW-1:0]   north_lane_c [N];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state and beat counter
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                end
            end
            ST_RUN: begin
                if (t_q == TW'(BEAT_CNT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Host writes land only in IDLE; a write on the start edge is seen by that run.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if ((state_q == ST_IDLE) && wr_en) begin
            case (wr_sel)
                WSEL_A: a_d[wr_row][wr_col] = wr_data;
                WSEL_B: b_d[wr_row][wr_col] = wr_data;
                default: ;
            endcase
        end
    end

    // Flatten A rows and B columns for the lane muxes
    always_comb begin
        a_row_c = '{default: '0};
        b_col_c = '{default: '0};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                a_row_c[i][k*DW +: DW] = a_d[i][k];
                b_col_c[i][k*DW +: DW] = b_d[k][i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        feeder_lane_mux u_west_mux (
            .vec    (a_row_c[i]),
            .lane   (AW'(i)),
            .t      (t_d),
            .elem_c (west_lane_c[i])
        );
        feeder_lane_mux u_north_mux (
            .vec    (b_col_c[i]),
            .lane   (AW'(i)),
            .t      (t_d),
            .elem_c (north_lane_c[i])
        );
    end

    // Outputs are computed from the next state so they align with the state they describe.
    always_comb begin
        west_d     = '0;
        north_d    = '0;
        valid_d    = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        wr_ready_d = (state_d == ST_IDLE);
        if (valid_d) begin
            for (int i = 0; i < N; i++) begin
                west_d[i*DW +: DW]  = west_lane_c[i];
                north_d[i*DW +: DW] = north_lane_c[i];
            end
        end
    end

    // Buffer and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q        <= '{default: '0};
            b_q        <= '{default: '0};
            west_q     <= '0;
            north_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            west_q     <= west_d;
            north_q    <= north_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign west_data    = west_q;
    assign north_data   = north_q;
    assign stream_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign wr_ready     = wr_ready_q;

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand injector for the systolic PE array. It is the transmitter for the PE inp_west/inp_north streams.
- Buffers an N x N matrix A and an N x N matrix B, both written by the host over a simple write port.
- On start, drives skewed, zero-padded operand streams into the west edge (rows of A) and north edge (columns of B).
- Sits between the host/memory interface and the PE grid edge inputs.

Parameters:
- N, 4, array dimension: lanes per edge and matrix order.
- DW, 8, operand width; matches the PE 8-bit inputs.
- AW, 2, index width per row/column field, equal to clog2(N); N=4 gives 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset; sampled only on the rising edge of clk.
- wr_en  in  1  buffer write strobe; accepted only when wr_ready=1.
- wr_sel  in  1  0 = write matrix A, 1 = write matrix B.
- wr_row  in  AW  row index.
- wr_col  in  AW  column index.
- wr_data  in  DW  element value.
- wr_ready  out  1  high in IDLE only.
- start  in  1  one-cycle request to begin streaming.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last stream beat.
- west_data  out  N*DW  lane i occupies bits [i*DW +: DW] and feeds PE row i west input.
- north_data  out  N*DW  lane j occupies bits [j*DW +: DW] and feeds PE column j north input.
- stream_valid  out  1  high on every cycle the stream counter is live (2N-1 beats).

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - west_data, north_data, stream_valid, busy and done all go to 0; wr_ready goes to 1.
  - All A/B buffer entries clear to 0.
  - Reset has priority over every other input, including mid-RUN; an aborted run produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - wr_en=1 writes wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the edge.
  - An edge with start=1 moves to RUN with t=0.
  - If wr_en and start are both high on the same edge, the write is performed first; the new value is used by the run.
- RUN:
  - Beat counter t runs 0 .. 2N-2, one beat per cycle; all outputs are registered.
  - Beat t is visible on the outputs in the cycle after the edge that set t, so the first beat appears one cycle after the start edge.
  - west lane i = A[i][t-i] when 0 <= t-i <= N-1, else 0.
  - north lane j = B[t-j][j] when 0 <= t-j <= N-1, else 0.
  - stream_valid=1 and busy=1 for exactly 2N-1 consecutive cycles.
  - wr_en is ignored (wr_ready=0) and buffer contents are frozen.
  - start is ignored.
  - After beat 2N-2 the next state is DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, stream_valid=0, data outputs 0.
  - Then IDLE unconditionally; a start asserted during DONE is ignored.
- Data outputs are 0 whenever stream_valid=0, including in IDLE.
- Index arithmetic is unsigned, with the difference t-i computed one bit wider than t.
- The t counter never wraps inside a run; it is reloaded to 0 on entry to RUN.
- Buffer contents persist across runs, so back-to-back runs can reuse operands or update them partially.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN, DONE);
  - WSEL_A=0 and WSEL_B=1;
  - the beat count constant, 2N-1.
- One sub-module is natural: feeder_lane_mux.
  - Takes one row (or column) of N elements, the lane index and t.
  - Returns the selected element or 0.
  - Instantiated N times per edge.
- Buffer storage and the FSM stay in the top module.

Test Plan (N=4, DW=8):
- Reset mid-run: start a run, pull rst low at beat 2 -> next cycle all outputs 0, busy=0, done never pulses, wr_ready=1; a subsequent read-back run streams all zeros.
- Basic skew: load A[i][k] = 10*i+k+1 and B[k][j] = 10*k+j+1, then pulse start. Required beats:
  - t=0: west = {0,0,0,1}, north = {0,0,0,1}.
  - t=3: west lane3 = 31, lane0 = 4.
  - t=6: west lane3 = 34 (the only nonzero lane).
  - done pulses on the 8th cycle after start (one cycle after the 7th beat).
- Write lockout: during RUN, write A[0][0]=0xFF -> ignored, wr_ready=0; a second run still shows west lane0 = 1 at t=0.
- Start ignored: assert start during RUN and during the DONE cycle -> exactly one 7-beat stream, one done pulse.
- Simultaneous write and start in IDLE: write B[0][0]=0x55 with start on the same edge -> north lane0 = 0x55 at t=0.
- Back-to-back runs: start in the first IDLE cycle after done -> second stream begins two cycles after done rose, with identical data (persistence).
